dcache: RTL and testbench
=========================

# dcache

Direct-mapped, write-through, no-write-allocate data cache sitting between the load/store unit and the data-memory bus. It accepts level-held load/store requests with low-justified data and byte enables, aligns them to the addressed word, serves load hits in one cycle, and forwards misses and all stores to memory through a request/valid handshake. Each completed access is reported with a one-cycle `dcache_rvalid`/`dcache_wvalid` pulse.

## Interface
- `INDEX_BITS`, 6, line-index width; 2**INDEX_BITS one-word lines.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `dcache_addr`  in  32  byte address from LSU.
- `dcache_rreq`  in  1  load request, held until `dcache_rvalid`.
- `dcache_wreq`  in  1  store request, held until `dcache_wvalid`.
- `dcache_wdata`  in  32  store data, low-justified.
- `dcache_byte_enable`  in  4  low-justified enable: 0001 byte, 0011 half, 1111 word.
- `dcache_rdata`  out  32  load data, right-shifted to bit 0.
- `dcache_rvalid`  out  1  load-complete pulse.
- `dcache_wvalid`  out  1  store-complete pulse.
- `mem_addr`  out  32  word-aligned memory address.
- `mem_rreq`  out  1  memory read request.
- `mem_wreq`  out  1  memory write request.
- `mem_wdata`  out  32  lane-aligned write data.
- `mem_byte_enable`  out  4  lane-aligned byte enable.
- `mem_rdata`  in  32  memory read word.
- `mem_rvalid`  in  1  read data valid, one cycle.
- `mem_wvalid`  in  1  write acknowledge, one cycle.

## Operation
- Address split: offset = addr[1:0], index = addr[INDEX_BITS+1:2], tag = addr[31:INDEX_BITS+2].
- Alignment: an effective offset is used for all shifting. Word accesses use 0, half accesses use {addr[1],0}, and byte accesses use addr[1:0].
  - Lane enable = `dcache_byte_enable << eff_offset`.
  - Write data = `dcache_wdata << 8*eff_offset`.
  - Load data = selected word `>> 8*eff_offset`, with the upper bits passed through unmasked (LSU performs extension).
- Arrays:
  - Valid bits are cleared by reset.
  - Tag and data arrays are not reset.
  - Hit = valid[index] && tag match, evaluated combinationally in IDLE.
- FSM states: IDLE, RD_MEM, WR_MEM, RESP.
  - IDLE with `dcache_wreq`:
    - If `dcache_byte_enable`==0000, go to RESP with `dcache_wvalid` and no memory access.
    - Otherwise go to WR_MEM.
    - `wreq` has priority if `rreq` is also high.
  - IDLE with `dcache_rreq`: on a hit, go to RESP with `dcache_rdata` registered and `dcache_rvalid` set. On a miss, go to RD_MEM.
  - RD_MEM: hold `mem_rreq`=1 with `mem_addr`={addr[31:2],2'b00}. On `mem_rvalid`:
    - write the line (valid=1, tag, data);
    - register the aligned `dcache_rdata`;
    - set `dcache_rvalid`;
    - go to RESP.
  - WR_MEM: hold `mem_wreq`, `mem_addr`, `mem_wdata` and `mem_byte_enable` stable. On `mem_wvalid`:
    - if the line hits, merge the enabled lanes into the cached word;
    - a miss does not allocate;
    - set `dcache_wvalid`;
    - go to RESP.
  - RESP: clear the valid pulses, ignore requests, and return to IDLE. This dead cycle lets the LSU's request lines move to the next instruction.
- `mem_rvalid`/`mem_wvalid` arriving outside RD_MEM/WR_MEM are ignored.
- Request address, data and enable are latched on leaving IDLE. Later input changes do not affect an in-flight access.

## Timing
- Reset values: FSM=IDLE, all valid bits 0, `dcache_rvalid`=`dcache_wvalid`=0, `dcache_rdata`=0, `mem_rreq`=`mem_wreq`=0, `mem_addr`=`mem_wdata`=0, `mem_byte_enable`=0.
- Reset asserted mid-access aborts immediately: memory requests drop asynchronously and no completion pulse is issued.
- Load hit: `rreq` sampled at edge N; `dcache_rvalid` is high during cycle N→N+1 (latency 1).
- Miss / store:
  - `mem_*req` rises the cycle after the request is sampled and stays high through the cycle in which `mem_rvalid`/`mem_wvalid` is sampled.
  - The request drops and the completion pulse appears the following cycle.
- Minimum spacing between accepted requests is 2 cycles (hit), because of the RESP cycle.
- All outputs are registered; there is no combinational path from `dcache_*` inputs to outputs.

## Test plan
- Reset, then lw 0x100 (miss, memory returns 0xDEADBEEF after 3 cycles). Expect:
  - `mem_rreq` held 3 cycles, `mem_addr`=0x100;
  - `rvalid` pulse with rdata 0xDEADBEEF;
  - a repeat lw 0x100 hits with latency 1 and no `mem_rreq`.
- lb 0x103 after the line above is cached → rdata 0x000000DE (low byte 0xDE), no memory access.
- sh 0x102 wdata 0x00001234 on the cached line → `mem_byte_enable` 1100, `mem_wdata` 0x12340000, `mem_addr` 0x100. After `mem_wvalid`, lw 0x100 hits and returns 0x1234BEEF.
- sw 0x2100 (same index as 0x100, different tag) → memory write only. lw 0x100 still hits and returns the old data, and the 0x2100 line stays invalid.
- `byte_enable` 0000 store → `wvalid` after 1 cycle with no `mem_wreq`. Simultaneous `rreq`+`wreq` → write is performed.
- Assert `rst_n` low during RD_MEM → `mem_rreq` drops immediately and no `rvalid` is issued. A lw to the previously cached address then misses.

Source files
------------

// File: rtl/dcache.sv
// Direct-mapped write-through, no-write-allocate data cache between LSU and memory bus.
// Latency: load hit 1 cycle; miss/store = memory latency + 1; RESP dead cycle after each access.
// Backpressure: LSU requests are level-held until the completion pulse; memory handshake holds req until rvalid/wvalid.
module dcache #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] dcache_addr,
  input  logic        dcache_rreq,
  input  logic        dcache_wreq,
  input  logic [31:0] dcache_wdata,
  input  logic [3:0]  dcache_byte_enable,
  output logic [31:0] dcache_rdata,
  output logic        dcache_rvalid,
  output logic        dcache_wvalid,
  output logic [31:0] mem_addr,
  output logic        mem_rreq,
  output logic        mem_wreq,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  input  logic        mem_wvalid
);
  localparam int LINES = 2**INDEX_BITS;
  localparam int TAG_W = 30 - INDEX_BITS;

  typedef enum logic [1:0] {IDLE, RD_MEM, WR_MEM, RESP} state_t;
  state_t state;

  logic [LINES-1:0]      valid_q;
  logic [TAG_W-1:0]      tag_mem [LINES];
  logic [31:0]           data_mem [LINES];
  logic [1:0]            eff_off;
  logic [1:0]            off_q;
  logic [29:0]           lk_word;
  logic [INDEX_BITS-1:0] idx;
  logic [TAG_W-1:0]      tag;
  logic                  hit;
  logic [31:0]           merged;

  always_comb begin
    if (dcache_byte_enable == 4'b1111)
      eff_off = 2'd0;
    else if (dcache_byte_enable == 4'b0011)
      eff_off = {dcache_addr[1], 1'b0};
    else
      eff_off = dcache_addr[1:0];
  end

  // Lookup uses the live LSU address in IDLE, the latched word address once in flight.
  assign lk_word = (state == IDLE) ? dcache_addr[31:2] : mem_addr[31:2];
  assign idx     = lk_word[INDEX_BITS-1:0];
  assign tag     = lk_word[29:INDEX_BITS];
  assign hit     = valid_q[idx] && (tag_mem[idx] == tag);

  always_comb begin
    merged = data_mem[idx];
    for (int i = 0; i < 4; i++)
      if (mem_byte_enable[i])
        merged[8*i +: 8] = mem_wdata[8*i +: 8];
  end

  always_ff @(posedge clk) begin
    if (state == RD_MEM && mem_rvalid) begin
      tag_mem[idx]  <= tag;
      data_mem[idx] <= mem_rdata;
    end else if (state == WR_MEM && mem_wvalid && hit) begin
      data_mem[idx] <= merged;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      valid_q         <= '0;
      off_q           <= '0;
      dcache_rdata    <= '0;
      dcache_rvalid   <= 1'b0;
      dcache_wvalid   <= 1'b0;
      mem_rreq        <= 1'b0;
      mem_wreq        <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      mem_byte_enable <= '0;
    end else begin
      case (state)
        IDLE: begin
          off_q <= eff_off;
          if (dcache_wreq) begin
            if (dcache_byte_enable == 4'b0000) begin
              dcache_wvalid <= 1'b1;
              state         <= RESP;
            end else begin
              mem_wreq        <= 1'b1;
              mem_addr        <= {dcache_addr[31:2], 2'b00};
              mem_wdata       <= dcache_wdata << {eff_off, 3'b000};
              mem_byte_enable <= dcache_byte_enable << eff_off;
              state           <= WR_MEM;
            end
          end else if (dcache_rreq) begin
            if (hit) begin
              dcache_rdata  <= data_mem[idx] >> {eff_off, 3'b000};
              dcache_rvalid <= 1'b1;
              state         <= RESP;
            end else begin
              mem_rreq <= 1'b1;
              mem_addr <= {dcache_addr[31:2], 2'b00};
              state    <= RD_MEM;
            end
          end
        end
        RD_MEM: if (mem_rvalid) begin
          valid_q[idx]  <= 1'b1;
          dcache_rdata  <= mem_rdata >> {off_q, 3'b000};
          dcache_rvalid <= 1'b1;
          mem_rreq      <= 1'b0;
          state         <= RESP;
        end
        WR_MEM: if (mem_wvalid) begin
          dcache_wvalid <= 1'b1;
          mem_wreq      <= 1'b0;
          state         <= RESP;
        end
        RESP: begin
          dcache_rvalid <= 1'b0;
          dcache_wvalid <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dcache.sv
// Bench for dcache: acts as LSU and memory, checks against a byte-level memory image plus a
// reference tag/valid directory; directed scenarios first, then randomized traffic.
module tb_dcache;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] dcache_addr = '0;
  logic        dcache_rreq = 1'b0;
  logic        dcache_wreq = 1'b0;
  logic [31:0] dcache_wdata = '0;
  logic [3:0]  dcache_byte_enable = '0;
  logic [31:0] dcache_rdata;
  logic        dcache_rvalid;
  logic        dcache_wvalid;
  logic [31:0] mem_addr;
  logic        mem_rreq;
  logic        mem_wreq;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_rdata = '0;
  logic        mem_rvalid = 1'b0;
  logic        mem_wvalid = 1'b0;

  dcache #(.INDEX_BITS(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .dcache_addr(dcache_addr), .dcache_rreq(dcache_rreq), .dcache_wreq(dcache_wreq),
    .dcache_wdata(dcache_wdata), .dcache_byte_enable(dcache_byte_enable),
    .dcache_rdata(dcache_rdata), .dcache_rvalid(dcache_rvalid), .dcache_wvalid(dcache_wvalid),
    .mem_addr(mem_addr), .mem_rreq(mem_rreq), .mem_wreq(mem_wreq), .mem_wdata(mem_wdata),
    .mem_byte_enable(mem_byte_enable), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .mem_wvalid(mem_wvalid)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  mem_b [logic [31:0]];
  bit          ref_valid [64];
  logic [23:0] ref_tag [64];
  logic [31:0] last_rdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    if (mem_b.exists(a)) return mem_b[a];
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    logic [31:0] base;
    base = a & 32'hFFFF_FFFC;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = rd_byte(base + 32'(k));
    return w;
  endfunction

  // One complete LSU access; called at a point where the DUT is, or will be next edge, idle.
  task automatic run_req(input bit wr, input bit rd, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wd, input int lat);
    int sh, nb, cyc, req_cyc;
    bit hit, mem_acc, done, saw_w;
    logic [5:0]  idx;
    logic [31:0] base, exp_mwd, exp_word;
    logic [3:0]  exp_mbe;
    idx     = addr[7:2];
    base    = addr & 32'hFFFF_FFFC;
    sh      = (be == 4'hF) ? 0 : (be == 4'h3) ? 2 * int'(addr[1]) : int'(addr[1:0]);
    nb      = (be == 4'hF) ? 4 : (be == 4'h3) ? 2 : 1;
    exp_mbe = be << sh;
    exp_mwd = wd << (8 * sh);
    hit     = ref_valid[idx] && (ref_tag[idx] == addr[31:8]);
    mem_acc = wr ? (be != 4'h0) : !hit;
    cyc = 0; req_cyc = 0; done = 0; saw_w = 0;

    @(negedge clk);
    dcache_addr = addr; dcache_rreq = rd; dcache_wreq = wr;
    dcache_wdata = wd; dcache_byte_enable = be;
    mem_rvalid = 1'b0; mem_wvalid = 1'b0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (dcache_rvalid || dcache_wvalid) begin
        done = 1; saw_w = dcache_wvalid; last_rdata = dcache_rdata;
        mem_rvalid = 1'b0; mem_wvalid = 1'b0;
      end else if (mem_rreq || mem_wreq) begin
        req_cyc++;
        check("mem_req_kind", 32'(mem_wreq), 32'(wr));
        check("mem_addr", mem_addr, base);
        if (wr) begin
          check("mem_wdata", mem_wdata, exp_mwd);
          check("mem_byte_enable", 32'(mem_byte_enable), 32'(exp_mbe));
        end
        // an in-flight access must not follow the LSU's lines
        dcache_addr = $urandom; dcache_wdata = $urandom; dcache_byte_enable = 4'($urandom);
        mem_rdata  = (req_cyc == lat && !wr) ? mem_word(addr) : $urandom;
        mem_rvalid = (req_cyc == lat) && !wr;
        mem_wvalid = (req_cyc == lat) && wr;
      end else begin
        mem_rvalid = 1'b0; mem_wvalid = 1'b0;
      end
    end
    dcache_rreq = 1'b0; dcache_wreq = 1'b0;
    if (!done) begin
      check("timeout", 0, 1);
      return;
    end
    check("done_kind", 32'(saw_w), 32'(wr));
    check("latency", 32'(cyc), mem_acc ? 32'(lat + 1) : 32'd1);
    check("mem_cycles", 32'(req_cyc), mem_acc ? 32'(lat) : 32'd0);
    if (!wr) begin
      exp_word = mem_word(addr);
      check("rdata", last_rdata, exp_word >> (8 * sh));
      if (!hit) begin
        ref_valid[idx] = 1'b1;
        ref_tag[idx]   = addr[31:8];
      end
    end else if (be != 4'h0) begin
      for (int k = 0; k < nb; k++) mem_b[base + 32'(sh + k)] = wd[8*k +: 8];
    end
    // dead cycle: pulses gone, stray memory strobes must be ignored
    @(negedge clk);
    check("resp_pulses", {30'd0, dcache_rvalid, dcache_wvalid}, 32'd0);
    check("resp_mem_req", {30'd0, mem_rreq, mem_wreq}, 32'd0);
    mem_rvalid = 1'b1; mem_wvalid = 1'b1; mem_rdata = $urandom;
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0]  be;
    bit          wr;
    mem_b[32'h100] = 8'hEF; mem_b[32'h101] = 8'hBE;
    mem_b[32'h102] = 8'hAD; mem_b[32'h103] = 8'hDE;
    repeat (3) @(negedge clk);
    check("rst_rdata", dcache_rdata, 32'd0);
    check("rst_pulses", {30'd0, dcache_rvalid, dcache_wvalid}, 32'd0);
    check("rst_mem_req", {30'd0, mem_rreq, mem_wreq}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_be", 32'(mem_byte_enable), 32'd0);
    rst_n = 1'b1;

    run_req(0, 1, 32'h100, 4'hF, 32'h0, 3);
    check("lw_miss_data", last_rdata, 32'hDEADBEEF);
    run_req(0, 1, 32'h100, 4'hF, 32'h0, 3);
    check("lw_hit_data", last_rdata, 32'hDEADBEEF);
    run_req(0, 1, 32'h103, 4'h1, 32'h0, 2);
    check("lb_hit_data", last_rdata, 32'h000000DE);
    run_req(1, 0, 32'h102, 4'h3, 32'h00001234, 2);
    run_req(0, 1, 32'h100, 4'hF, 32'h0, 2);
    check("sh_merge_data", last_rdata, 32'h1234BEEF);
    run_req(1, 0, 32'h2100, 4'hF, 32'hA5A5_5A5A, 1);
    run_req(0, 1, 32'h100, 4'hF, 32'h0, 2);
    check("no_alloc_old_data", last_rdata, 32'h1234BEEF);
    run_req(0, 1, 32'h2100, 4'hF, 32'h0, 2);
    check("no_alloc_miss_data", last_rdata, 32'hA5A5_5A5A);
    run_req(1, 0, 32'h200, 4'h0, 32'hFFFF_FFFF, 1);
    run_req(1, 1, 32'h104, 4'hF, 32'hCAFEF00D, 2);
    run_req(0, 1, 32'h104, 4'hF, 32'h0, 1);
    check("rw_pri_data", last_rdata, 32'hCAFEF00D);

    // reset in the middle of a line fill
    run_req(0, 1, 32'h100, 4'hF, 32'h0, 1);
    @(negedge clk);
    dcache_addr = 32'h300; dcache_rreq = 1'b1; dcache_byte_enable = 4'hF;
    mem_rvalid = 1'b0; mem_wvalid = 1'b0;
    @(negedge clk);
    check("abort_rreq_up", 32'(mem_rreq), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_rreq_drop", 32'(mem_rreq), 32'd0);
    dcache_rreq = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
    @(negedge clk);
    check("abort_no_rvalid", 32'(dcache_rvalid), 32'd0);
    mem_rvalid = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) ref_valid[i] = 1'b0;
    @(negedge clk);
    check("abort_no_rvalid2", 32'(dcache_rvalid), 32'd0);
    run_req(0, 1, 32'h100, 4'hF, 32'h0, 2);
    check("post_reset_data", last_rdata, 32'h1234BEEF);

    for (int t = 0; t < 300; t++) begin
      a  = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      wr = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 2))
        0:       be = 4'h1;
        1:       be = 4'h3;
        default: be = 4'hF;
      endcase
      if (wr && $urandom_range(0, 7) == 0) be = 4'h0;
      run_req(wr, wr ? ($urandom_range(0, 3) == 0) : 1'b1, a, be, $urandom, $urandom_range(1, 4));
    end

    @(negedge clk);
    mem_rvalid = 1'b0; mem_wvalid = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
